// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and the
// clock mode constants used by both spi_slave and spi_master.
package spi_slave_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Mode 1: sclk idles low, data driven on the rising edge, sampled on falling
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Parallel-side bus of the SPI slave: transmit handshake, received data and
// status pulses. The slave modport is the SPI block, master is its user.
interface spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  tx_underrun;
  logic                  rx_abort;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_abort
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_abort
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus one-clk rise/fall
// pulses derived from the synchronized level.
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter bit IDLE_LEVEL = SPI_CPOL
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] pipe;
  logic              prev;

  // Shift the pin through the chain; prev remembers the last synchronized level
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe <= {STAGES{IDLE_LEVEL}};
      prev <= IDLE_LEVEL;
    end else begin
      pipe <= STAGES'({pipe, din});
      prev <= pipe[STAGES-1];
    end
  end

  assign level = pipe[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, mode 1, MSB first. All SPI pins are oversampled in the clk
// domain; a one-entry holding buffer feeds the transmit shifter.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  spi_slave_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_level_unused;
  logic sclk_rise, sclk_fall;
  logic cs_level_unused;
  logic cs_rise, cs_fall;

  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   mosi_sync;

  spi_state_e state, state_next;

  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_shift_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  rx_abort;

  logic do_load, do_drive, do_sample, do_complete, do_cancel, leaving;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SPI_CPOL)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (cs),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi only needs the same delay as sclk so data lines up with its edge
  always_ff @(posedge clk) begin
    if (!reset) mosi_pipe <= '0;
    else        mosi_pipe <= SYNC_STAGES'({mosi_pipe, mosi});
  end

  assign mosi_sync     = mosi_pipe[SYNC_STAGES-1];
  assign rx_shift_next = DATA_WIDTH'({rx_shift, mosi_sync});
  assign tx_ready      = ~hold_full;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and datapath strobes; a completing frame wins over a cs release
  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_drive    = 1'b0;
    do_sample   = 1'b0;
    do_complete = 1'b0;
    do_cancel   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_rise) begin
          do_cancel  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          do_load    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sclk_fall && (bit_cnt == LAST_BIT)) begin
          do_sample   = 1'b1;
          do_complete = 1'b1;
          state_next  = cs_rise ? ST_IDLE : ST_LOAD;
        end else if (cs_rise) begin
          do_cancel  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          do_drive  = sclk_rise;
          do_sample = sclk_fall;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign leaving = (state != ST_IDLE) && (state_next == ST_IDLE);

  // Datapath: holding buffer, shifters, bit counter and one-clk status pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_abort    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_abort    <= 1'b0;

      if (do_load) begin
        tx_shift    <= hold_full ? hold_data : '0;
        tx_underrun <= ~hold_full;
        hold_full   <= 1'b0;
        bit_cnt     <= '0;
      end

      if (bus.tx_valid && tx_ready) begin
        hold_data <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (do_drive) begin
        miso     <= tx_shift[DATA_WIDTH-1];
        tx_shift <= tx_shift << 1;
      end

      if (do_sample) begin
        rx_shift <= rx_shift_next;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end

      if (do_complete) begin
        rx_data  <= rx_shift_next;
        rx_valid <= 1'b1;
        bit_cnt  <= '0;
      end

      if (do_cancel) begin
        rx_abort <= (bit_cnt != '0);
        bit_cnt  <= '0;
      end

      if (leaving) miso <= 1'b0;
    end
  end

  assign bus.tx_ready    = tx_ready;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.tx_underrun = tx_underrun;
  assign bus.rx_abort    = rx_abort;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-1 master model at sclk = clk/10, a transmit
// feeder and a pulse monitor, checked against a queue-based reference.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic miso;

  spi_slave_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sclk  (sclk),
    .cs    (cs),
    .mosi  (mosi),
    .miso  (miso),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // observed activity
  int rx_valid_cnt = 0;
  int underrun_cnt = 0;
  int abort_cnt = 0;
  int accept_cnt = 0;
  int pulse_wide = 0;
  logic [7:0] rx_got[$];
  bit prev_rv = 1'b0, prev_ur = 1'b0, prev_ab = 1'b0;

  // reference model
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int exp_underruns = 0;
  int exp_rx = 0;
  int exp_aborts = 0;
  logic [7:0] cur_exp = 8'h00;
  logic [7:0] last_rx = 8'h00;

  // Count status pulses once per clk and keep every received word
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_valid_cnt++;
      rx_got.push_back(bus.rx_data);
    end
    if (bus.tx_underrun === 1'b1) underrun_cnt++;
    if (bus.rx_abort === 1'b1) abort_cnt++;
    if ((bus.rx_valid && prev_rv) || (bus.tx_underrun && prev_ur) || (bus.rx_abort && prev_ab))
      pulse_wide++;
    prev_rv = bus.rx_valid;
    prev_ur = bus.tx_underrun;
    prev_ab = bus.rx_abort;
  end

  // Present queued tx bytes; valid stays high while bytes remain
  bit hs;
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    hs = 1'b0;
    forever begin
      @(negedge clk);
      if (hs) begin
        accept_cnt++;
        bus.tx_valid = 1'b0;
      end
      if (!bus.tx_valid && tx_q.size() > 0) begin
        bus.tx_data  = tx_q.pop_front();
        bus.tx_valid = 1'b1;
      end
      hs = bus.tx_valid && bus.tx_ready;
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Every frame start takes the oldest buffered byte, or sends zeros
  task automatic model_start();
    if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    else begin
      cur_exp = 8'h00;
      exp_underruns++;
    end
  endtask

  // Mode-1 master: drive mosi on sclk rise, sample miso on sclk fall
  task automatic applyStimulus(input logic [7:0] mo, input int nbits, input bit release_last,
                               output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sclk = 1'b1;
      mosi = mo[7-i];
      repeat (4) @(negedge clk);
      @(negedge clk);
      sclk = 1'b0;
      mi = {mi[6:0], miso};
      if (release_last && (i == nbits - 1)) cs = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cs_select();
    @(negedge clk);
    cs = 1'b0;
    model_start();
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_release();
    @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] mo, input bit last, input string tag);
    logic [7:0] mi;
    logic [7:0] want;
    logic [7:0] got;
    want = cur_exp;
    applyStimulus(mo, 8, last, mi);
    checkOutput({tag, " master rx"}, 32'(mi), 32'(want));
    exp_rx++;
    checkOutput({tag, " rx_valid count"}, rx_valid_cnt, exp_rx);
    checkOutput({tag, " rx words pending"}, rx_got.size(), 32'd1);
    if (rx_got.size() > 0) begin
      got = rx_got.pop_front();
      checkOutput({tag, " rx word"}, 32'(got), 32'(mo));
    end
    checkOutput({tag, " rx_data"}, 32'(bus.rx_data), 32'(mo));
    last_rx = mo;
    if (!last) model_start();
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " miso"}, 32'(miso), 32'd0);
    checkOutput({tag, " underruns"}, underrun_cnt, exp_underruns);
    checkOutput({tag, " aborts"}, abort_cnt, exp_aborts);
    checkOutput({tag, " rx_valid total"}, rx_valid_cnt, exp_rx);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " miso"}, 32'(miso), 32'd0);
    checkOutput({tag, " rx_data"}, 32'(bus.rx_data), 32'd0);
    checkOutput({tag, " rx_valid"}, 32'(bus.rx_valid), 32'd0);
    checkOutput({tag, " tx_ready"}, 32'(bus.tx_ready), 32'd1);
    checkOutput({tag, " tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
    checkOutput({tag, " rx_abort"}, 32'(bus.rx_abort), 32'd0);
  endtask

  logic [7:0] b, prev_rx, mi4;
  int a0, nfr, npush;

  initial begin
    $display("[TB] start");
    repeat (4) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // single frame with preloaded byte
    push_tx(8'hA5);
    repeat (5) @(negedge clk);
    checkOutput("t1 tx_ready full", 32'(bus.tx_ready), 32'd0);
    cs_select();
    checkOutput("t1 busy", 32'(bus.busy), 32'd1);
    run_frame(8'hAC, 1'b0, "t1");
    cs_release();
    check_idle("t1");
    checkOutput("t1 tx_ready", 32'(bus.tx_ready), 32'd1);

    // back-to-back frames with cs held low
    push_tx(8'h3C);
    push_tx(8'hC3);
    repeat (5) @(negedge clk);
    cs_select();
    run_frame(8'h11, 1'b0, "t2a");
    run_frame(8'h22, 1'b0, "t2b");
    cs_release();
    check_idle("t2");

    // empty buffer: underrun and all-zero miso; cs released with the last fall
    cs_select();
    run_frame(8'h5A, 1'b1, "t3");
    repeat (6) @(negedge clk);
    check_idle("t3");

    // cs released after four bits
    b = 8'($urandom());
    push_tx(b);
    repeat (5) @(negedge clk);
    prev_rx = last_rx;
    cs_select();
    applyStimulus(8'($urandom()), 4, 1'b0, mi4);
    checkOutput("t4 partial master rx", 32'(mi4[3:0]), 32'(b[7:4]));
    cs_release();
    exp_aborts++;
    check_idle("t4");
    checkOutput("t4 rx_data kept", 32'(bus.rx_data), 32'(prev_rx));

    // reset after three bits, then a clean frame
    push_tx(8'($urandom()));
    repeat (5) @(negedge clk);
    cs_select();
    applyStimulus(8'($urandom()), 3, 1'b0, mi4);
    @(negedge clk);
    reset = 1'b0;
    cs = 1'b1;
    @(negedge clk);
    check_reset_values("t5 reset");
    exp_q.delete();
    last_rx = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("t5 after reset");
    push_tx(8'($urandom()));
    repeat (5) @(negedge clk);
    cs_select();
    run_frame(8'hF0, 1'b1, "t5");
    repeat (6) @(negedge clk);
    check_idle("t5 end");

    // tx_valid held high: one byte accepted per frame
    a0 = accept_cnt;
    push_tx(8'($urandom()));
    push_tx(8'($urandom()));
    push_tx(8'($urandom()));
    repeat (6) @(negedge clk);
    checkOutput("t6 tx_ready full", 32'(bus.tx_ready), 32'd0);
    checkOutput("t6 accepted first", accept_cnt - a0, 32'd1);
    cs_select();
    run_frame(8'($urandom()), 1'b0, "t6a");
    run_frame(8'($urandom()), 1'b1, "t6b");
    repeat (6) @(negedge clk);
    checkOutput("t6 accepted per frame", accept_cnt - a0, 32'd3);
    checkOutput("t6 tx_ready held", 32'(bus.tx_ready), 32'd0);
    cs_select();
    run_frame(8'($urandom()), 1'b1, "t6c");
    repeat (6) @(negedge clk);
    checkOutput("t6 drained tx_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("t6 accepted total", accept_cnt - a0, 32'd3);
    check_idle("t6");

    // random sessions
    for (int s = 0; s < 4; s++) begin
      nfr = int'($urandom_range(1, 3));
      npush = int'($urandom_range(0, nfr));
      for (int k = 0; k < npush; k++) push_tx(8'($urandom()));
      repeat (5) @(negedge clk);
      cs_select();
      for (int f = 0; f < nfr; f++) run_frame(8'($urandom()), (f == nfr - 1), "rnd");
      repeat (6) @(negedge clk);
      check_idle("rnd");
    end

    checkOutput("pulse width", pulse_wide, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
